// File: rtl/muldiv_sequencer_pkg.sv
// Shared op codes, ALU control codes and state encoding for the HI/LO unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package muldiv_sequencer_pkg;

    // Operation codes presented on op
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Team ALU control codes; this unit only ever asks for add or sub
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEG_A  = 3'd1,
        ST_NEG_B  = 3'd2,
        ST_ITER   = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5
    } md_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO; all arithmetic via an external ALU.
// Latency: MTHI/MTLO/divide-by-zero 1 edge; MULTU/DIVU 32 busy cycles; MULT/DIV 34, or 36 with sign fix.
// Backpressure: start is ignored while busy=1; cancel aborts to IDLE with HI/LO untouched.
//
// Ports: clk, reset_n (async active-low); start/op/rs_val/rt_val request; cancel flush;
//        busy, hi, lo results; alu_a/alu_b/alu_ctrl drive the ALU, alu_out is its same-cycle result.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out
);

    // Carry/borrow out of bit 31 recovered from operand and result MSBs,
    // since the shared ALU exposes no carry output.
    function automatic logic add_carry(input logic a31, input logic b31, input logic s31);
        return (a31 & b31) | ((a31 | b31) & ~s31);
    endfunction

    function automatic logic sub_borrow(input logic a31, input logic b31, input logic s31);
        return (~a31 & b31) | ((~a31 | b31) & s31);
    endfunction

    md_state_t   state, state_nxt;
    // a_q doubles as Q (multiplier / dividend -> quotient), p_q as P / R.
    logic [31:0] a_q, a_nxt;
    logic [31:0] b_q, b_nxt;
    logic [31:0] p_q, p_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        is_div, is_div_nxt;
    logic        is_sgn, is_sgn_nxt;
    logic        sign_a, sign_a_nxt;
    logic        sign_b, sign_b_nxt;
    logic        z_q, z_nxt;
    logic [31:0] hi_q, hi_nxt;
    logic [31:0] lo_q, lo_nxt;

    logic        mul_c;
    logic [31:0] mul_s;
    logic [31:0] div_rsh;
    logic        div_take;
    logic        fix_needed;

    assign busy = (state != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        state_nxt  = state;
        a_nxt      = a_q;
        b_nxt      = b_q;
        p_nxt      = p_q;
        cnt_nxt    = cnt;
        is_div_nxt = is_div;
        is_sgn_nxt = is_sgn;
        sign_a_nxt = sign_a;
        sign_b_nxt = sign_b;
        z_nxt      = z_q;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        alu_a      = 32'h0;
        alu_b      = 32'h0;
        alu_ctrl   = ALU_ADD;
        mul_c      = 1'b0;
        mul_s      = p_q;
        div_rsh    = {p_q[30:0], a_q[31]};
        div_take   = 1'b0;
        // Product/quotient flip on differing signs; remainder follows the dividend.
        fix_needed = is_sgn & ((sign_a ^ sign_b) | (is_div & sign_a));

        case (state)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        MD_MTHI: hi_nxt = rs_val;
                        MD_MTLO: lo_nxt = rs_val;
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            if ((op == MD_DIV || op == MD_DIVU) && rt_val == 32'h0) begin
                                hi_nxt = rs_val;
                                lo_nxt = 32'hFFFF_FFFF;
                            end else begin
                                a_nxt      = rs_val;
                                b_nxt      = rt_val;
                                p_nxt      = 32'h0;
                                cnt_nxt    = 6'd0;
                                is_div_nxt = (op == MD_DIV || op == MD_DIVU);
                                is_sgn_nxt = (op == MD_MULT || op == MD_DIV);
                                sign_a_nxt = 1'b0;
                                sign_b_nxt = 1'b0;
                                z_nxt      = 1'b0;
                                state_nxt  = (op == MD_MULT || op == MD_DIV) ? ST_NEG_A : ST_ITER;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_NEG_A: begin
                alu_ctrl   = ALU_SUB;
                alu_b      = a_q;
                sign_a_nxt = a_q[31];
                if (a_q[31]) a_nxt = alu_out;
                state_nxt  = ST_NEG_B;
            end
            ST_NEG_B: begin
                alu_ctrl   = ALU_SUB;
                alu_b      = b_q;
                sign_b_nxt = b_q[31];
                if (b_q[31]) b_nxt = alu_out;
                state_nxt  = ST_ITER;
            end
            ST_ITER: begin
                cnt_nxt = cnt + 6'd1;
                if (!is_div) begin
                    // Shift-add: conditionally add b into P, then shift {c,P,Q} right.
                    alu_a = p_q;
                    alu_b = b_q;
                    if (a_q[0]) begin
                        mul_s = alu_out;
                        mul_c = add_carry(p_q[31], b_q[31], alu_out[31]);
                    end
                    p_nxt = {mul_c, mul_s[31:1]};
                    a_nxt = {mul_s[0], a_q[31:1]};
                end else begin
                    // Restoring: bit shifted out of R (p_q[31]) guarantees R' >= b.
                    alu_ctrl = ALU_SUB;
                    alu_a    = div_rsh;
                    alu_b    = b_q;
                    div_take = p_q[31] | ~sub_borrow(div_rsh[31], b_q[31], alu_out[31]);
                    p_nxt    = div_take ? alu_out : div_rsh;
                    a_nxt    = {a_q[30:0], div_take};
                end
                if (cnt == 6'(ITERATIONS - 1)) begin
                    if (fix_needed) begin
                        state_nxt = ST_FIX_LO;
                    end else begin
                        hi_nxt    = p_nxt;
                        lo_nxt    = a_nxt;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FIX_LO: begin
                if (!is_div || (sign_a ^ sign_b)) begin
                    alu_ctrl = ALU_SUB;
                    alu_b    = a_q;
                    a_nxt    = alu_out;
                end
                // Carry into the upper word of a 64-bit negate happens only when lo was 0.
                if (!is_div) z_nxt = (a_q == 32'h0);
                state_nxt = ST_FIX_HI;
            end
            ST_FIX_HI: begin
                if (!is_div) begin
                    alu_a = ~p_q;
                    alu_b = {31'h0, z_q};
                    p_nxt = alu_out;
                end else if (sign_a) begin
                    alu_ctrl = ALU_SUB;
                    alu_b    = p_q;
                    p_nxt    = alu_out;
                end
                hi_nxt    = p_nxt;
                lo_nxt    = a_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (cancel) begin
            state_nxt = ST_IDLE;
            hi_nxt    = hi_q;
            lo_nxt    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            a_q    <= 32'h0;
            b_q    <= 32'h0;
            p_q    <= 32'h0;
            cnt    <= 6'd0;
            is_div <= 1'b0;
            is_sgn <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            z_q    <= 1'b0;
            hi_q   <= 32'h0;
            lo_q   <= 32'h0;
        end else begin
            state  <= state_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            p_q    <= p_nxt;
            cnt    <= cnt_nxt;
            is_div <= is_div_nxt;
            is_sgn <= is_sgn_nxt;
            sign_a <= sign_a_nxt;
            sign_b <= sign_b_nxt;
            z_q    <= z_nxt;
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
        end
    end

endmodule
